dm_port_arbiter: RTL and testbench

DM_PORT_ARBITER -- requirements
Module: dm_port_arbiter

---
 rtl/dm_port_arbiter.sv | 97 +++++++++
 tb/tb_dm_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and a loader/debug port.
// The loader gets one-cycle accesses with a bounded CPU burst length while it waits.
module dm_port_arbiter #(
  parameter int unsigned CPU_BURST = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [7:0]  ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_ack,
  output logic [31:0] ld_rdata,
  output logic [7:0]  mem_a,
  output logic [31:0] mem_d,
  output logic        mem_we,
  input  logic [31:0] mem_spo,
  output logic        owner
);

  typedef enum logic [1:0] {
    S_CPU,
    S_LD,
    S_ACK
  } state_t;

  localparam logic [3:0] BURST = 4'(CPU_BURST);

  state_t      state_q, state_d, state;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] ld_rdata_q, ld_rdata_d;
  logic        grant;

  // The loader access cycle is granted combinationally out of S_CPU, so the
  // effective state S_LD exists only for that cycle and never sits in state_q.
  always_comb begin
    grant      = rstn && (state_q == S_CPU) && ld_req &&
                 (!cpu_req || (streak_q == BURST));
    state      = grant ? S_LD : state_q;
    state_d    = S_CPU;
    streak_d   = streak_q;
    ld_rdata_d = ld_rdata_q;

    case (state)
      S_CPU:   state_d = S_CPU;
      S_LD:    state_d = S_ACK;
      S_ACK:   state_d = S_CPU;
      default: state_d = S_CPU;
    endcase

    if (!ld_req || grant) begin
      streak_d = '0;
    end else if (cpu_req && (streak_q != BURST)) begin
      streak_d = 4'(streak_q + 4'd1);
    end

    if (grant) begin
      ld_rdata_d = mem_spo;
    end
  end

  always_comb begin
    owner     = grant;
    cpu_stall = grant & cpu_req;
    mem_a     = cpu_addr;
    mem_d     = cpu_wdata;
    mem_we    = cpu_req & cpu_we;
    if (grant) begin
      mem_a  = ld_addr;
      mem_d  = ld_wdata;
      mem_we = ld_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_CPU;
      streak_q   <= '0;
      ld_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      ld_rdata_q <= ld_rdata_d;
    end
  end

  assign ld_ack    = (state_q == S_ACK);
  assign ld_rdata  = ld_rdata_q;
  assign cpu_rdata = mem_spo;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: an abstract per-cycle model checked on every
// falling edge, plus directed scenarios with hand-computed literal values.
module tb_dm_port_arbiter;

  localparam int unsigned BURST = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ld_req, ld_we;
  logic [7:0]  ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_ack;
  logic [31:0] ld_rdata;
  logic [7:0]  mem_a;
  logic [31:0] mem_d;
  logic        mem_we;
  logic [31:0] mem_spo;
  logic        owner;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.CPU_BURST(BURST)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_ack    (ld_ack),
    .ld_rdata  (ld_rdata),
    .mem_a     (mem_a),
    .mem_d     (mem_d),
    .mem_we    (mem_we),
    .mem_spo   (mem_spo),
    .owner     (owner)
  );

  // Environment memory: asynchronous read, synchronous write.
  logic [31:0] mem [256] = '{default: '0};
  assign mem_spo = mem[mem_a];
  always @(posedge clk) if (mem_we) mem[mem_a] <= mem_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Abstract model: whether an ack is owed this cycle, how many CPU grants the
  // waiting loader has watched, and the memory contents the grants imply.
  bit          en       = 1'b0;
  bit          m_ack    = 1'b0;
  int unsigned m_streak = 0;
  logic [31:0] m_rdata  = '0;
  logic [31:0] ref_mem [256] = '{default: '0};

  always @(negedge clk) begin
    bit          g;
    logic [7:0]  ea;
    logic [31:0] ed;
    logic        ew;
    g  = (rstn === 1'b1) && !m_ack && ld_req && (!cpu_req || m_streak >= BURST);
    ea = g ? ld_addr  : cpu_addr;
    ed = g ? ld_wdata : cpu_wdata;
    ew = g ? ld_we    : (cpu_req & cpu_we);
    if (en) begin
      chk("owner",     owner,     32'(g));
      chk("cpu_stall", cpu_stall, 32'(g & cpu_req));
      chk("mem_a",     mem_a,     ea);
      chk("mem_d",     mem_d,     ed);
      chk("mem_we",    mem_we,    ew);
      chk("ld_ack",    ld_ack,    32'(m_ack));
      chk("ld_rdata",  ld_rdata,  m_rdata);
      chk("cpu_rdata", cpu_rdata, ref_mem[ea]);
    end
    if (rstn !== 1'b1) begin
      m_ack    = 1'b0;
      m_streak = 0;
      m_rdata  = '0;
    end else begin
      if (g) m_rdata = ref_mem[ld_addr];
      m_ack = g;
      if (!ld_req || g) m_streak = 0;
      else if (cpu_req && m_streak < BURST) m_streak = m_streak + 1;
    end
    if (ew) ref_mem[ea] = ed;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_ld(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
    ld_req = r; ld_we = w; ld_addr = a; ld_wdata = d;
  endtask

  task automatic idle();
    next(); rstn = 1'b1; set_cpu(0, 0, 8'h00, '0); set_ld(0, 0, 8'h00, '0);
  endtask

  initial begin
    // Reset with both requesters asking: the CPU path must be the only one seen.
    rstn = 1'b0; set_cpu(1, 0, 8'h05, '0); set_ld(1, 1, 8'h10, 32'hDEADBEEF);
    settle();
    chk("rst_owner", owner, 0); chk("rst_stall", cpu_stall, 0);
    chk("rst_mem_a", mem_a, 8'h05); chk("rst_mem_we", mem_we, 0);
    next(); en = 1'b1; settle();
    chk("rst_ack", ld_ack, 0); chk("rst_rdata", ld_rdata, 0);

    // Loader write alone, then CPU readback.
    next(); rstn = 1'b1; set_cpu(0, 0, 8'h00, '0); set_ld(1, 1, 8'h10, 32'hDEADBEEF);
    settle();
    chk("ldw_owner", owner, 1); chk("ldw_we", mem_we, 1);
    chk("ldw_a", mem_a, 8'h10); chk("ldw_stall", cpu_stall, 0);
    next(); settle();
    chk("ldw_ack", ld_ack, 1); chk("ldw_ack_owner", owner, 0);
    next(); set_ld(0, 0, 8'h00, '0); set_cpu(1, 0, 8'h10, '0);
    settle(); chk("ldw_readback", cpu_rdata, 32'hDEADBEEF);

    // Loader read of a word the CPU wrote.
    next(); set_cpu(1, 1, 8'h20, 32'h12345678);
    next(); set_cpu(0, 0, 8'h00, '0); set_ld(1, 0, 8'h20, '0);
    settle(); chk("ldr_owner", owner, 1);
    next(); settle();
    chk("ldr_ack", ld_ack, 1); chk("ldr_data", ld_rdata, 32'h12345678);
    idle();

    // Contention: four CPU grants, one loader grant stalling the CPU once.
    next(); set_cpu(1, 0, 8'h10, '0); set_ld(1, 1, 8'h30, 32'hA5A5A5A5);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) next();
      settle(); chk("cont_cpu_owner", owner, 0); chk("cont_cpu_stall", cpu_stall, 0);
    end
    next(); settle(); chk("cont_ld_owner", owner, 1); chk("cont_ld_stall", cpu_stall, 1);
    next(); settle(); chk("cont_ack", ld_ack, 1); chk("cont_ack_stall", cpu_stall, 0);
    idle();

    // Back-to-back loader with the request held across acks.
    for (int k = 0; k < 6; k++) begin
      next(); set_cpu(0, 0, 8'h00, '0); set_ld(1, 1, 8'h50, 32'hCAFE0000);
      settle();
      chk("b2b_owner", owner, 32'(k % 2 == 0));
      chk("b2b_ack", ld_ack, 32'(k % 2 == 1));
    end
    idle();

    // Reset in the cycle the loader would be granted; streak must restart from 0.
    for (int i = 0; i < 2; i++) begin
      next(); set_cpu(1, 0, 8'h41, '0); set_ld(1, 1, 8'h60, 32'h77777777);
      settle(); chk("pre_rst_owner", owner, 0);
    end
    next(); rstn = 1'b0; set_cpu(0, 0, 8'h41, '0);
    settle(); chk("mid_rst_owner", owner, 0);
    next(); rstn = 1'b1; set_cpu(1, 0, 8'h41, '0);
    settle(); chk("post_rst_ack", ld_ack, 0); chk("post_rst_owner", owner, 0);
    for (int i = 0; i < 3; i++) begin
      next(); settle(); chk("post_rst_cpu", owner, 0);
    end
    next(); settle(); chk("post_rst_grant", owner, 1);
    next(); settle(); chk("post_rst_ack2", ld_ack, 1);
    idle();

    // CPU write held while the loader writes the same address: grant order wins.
    for (int i = 0; i < 4; i++) begin
      next(); set_cpu(1, 0, 8'h41, '0); set_ld(1, 1, 8'h40, 32'h11111111);
    end
    next(); set_cpu(1, 1, 8'h40, 32'h0BADF00D);
    settle();
    chk("cw_stall", cpu_stall, 1); chk("cw_we", mem_we, 1);
    chk("cw_a", mem_a, 8'h40); chk("cw_ld_d", mem_d, 32'h11111111);
    next(); settle();
    chk("cw_ack", ld_ack, 1); chk("cw_late_stall", cpu_stall, 0);
    chk("cw_late_we", mem_we, 1); chk("cw_late_d", mem_d, 32'h0BADF00D);
    next(); set_ld(0, 0, 8'h00, '0); set_cpu(1, 0, 8'h40, '0);
    settle(); chk("cw_order", cpu_rdata, 32'h0BADF00D);
    idle();

    // Loader drops its request before the ack: access still completes.
    next(); set_ld(1, 0, 8'h10, '0);
    settle(); chk("drop_owner", owner, 1);
    next(); set_ld(0, 0, 8'h00, '0);
    settle(); chk("drop_ack", ld_ack, 1); chk("drop_rdata", ld_rdata, 32'hDEADBEEF);
    idle();
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
